// File: rtl/spi_defs.sv
// Register offsets and FSM state encodings shared by the SPI master RTL
// and the firmware-facing register decode.
package spi_defs;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;
endpackage

// File: rtl/spi_clkgen.sv
// SCLK phase counter: raises tick on the last cycle of each DIV+1 cycle phase.
module spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_reg;

  // Compare with >= so a divider lowered mid-phase ends the phase instead of wrapping.
  assign tick = run && (cnt_reg >= div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (!run || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end
endmodule

// File: rtl/spi_master.sv
// Memory-mapped SPI master, mode 0, 8-bit MSB-first, with programmable SCLK divider
// and software-controlled chip select.
module spi_master
  import spi_defs::*;
#(
  parameter int               DIV_W     = 8,
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(3)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);
  state_t           state_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       rx_byte_reg;
  logic [2:0]       bit_cnt_reg;
  logic             miso_s_reg;
  logic             sclk_reg;
  logic             mosi_reg;
  logic             cs_en_reg;
  logic             rx_valid_reg;
  logic [DIV_W-1:0] div_reg;
  logic [31:0]      rdata_reg;
  logic             tick;
  logic             busy;
  logic             wr;
  logic             rd;
  logic             start;
  logic             done;
  logic             unused_wdata;

  assign wr           = sel && (we == 4'b1111);
  assign rd           = sel && re;
  assign busy         = (state_reg != ST_IDLE);
  assign start        = wr && (addr == ADDR_DATA) && !busy;
  assign done         = (state_reg == ST_HI) && tick && (bit_cnt_reg == 3'd7);
  assign unused_wdata = ^wdata;

  assign sclk  = sclk_reg;
  assign mosi  = mosi_reg;
  assign cs_n  = ~cs_en_reg;
  assign rdata = rdata_reg;

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .run   (busy),
    .div   (div_reg),
    .tick  (tick)
  );

  // miso is captured on the LO->HI edge and folded into the shifter on HI->LO,
  // so the byte being transmitted stays intact until its bit has been sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      rx_byte_reg <= '0;
      bit_cnt_reg <= '0;
      miso_s_reg  <= 1'b0;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_LO;
            shift_reg   <= wdata[7:0];
            mosi_reg    <= wdata[7];
            bit_cnt_reg <= '0;
          end
        end
        ST_LO: begin
          if (tick) begin
            state_reg  <= ST_HI;
            sclk_reg   <= 1'b1;
            miso_s_reg <= miso;
          end
        end
        ST_HI: begin
          if (tick) begin
            sclk_reg <= 1'b0;
            if (bit_cnt_reg == 3'd7) begin
              state_reg   <= ST_IDLE;
              rx_byte_reg <= {shift_reg[6:0], miso_s_reg};
            end else begin
              state_reg   <= ST_LO;
              shift_reg   <= {shift_reg[6:0], miso_s_reg};
              mosi_reg    <= shift_reg[6];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_en_reg    <= 1'b0;
      div_reg      <= DIV_RESET;
      rx_valid_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      if (wr && (addr == ADDR_CTRL)) cs_en_reg <= wdata[0];
      if (wr && (addr == ADDR_DIV))  div_reg   <= wdata[DIV_W-1:0];

      // A completing transfer beats a same-cycle DATA read.
      if (done) begin
        rx_valid_reg <= 1'b1;
      end else if (rd && (addr == ADDR_DATA)) begin
        rx_valid_reg <= 1'b0;
      end

      if (rd) begin
        case (addr)
          ADDR_CTRL: rdata_reg <= {29'b0, rx_valid_reg, busy, cs_en_reg};
          ADDR_DATA: rdata_reg <= {24'b0, rx_byte_reg};
          ADDR_DIV:  rdata_reg <= 32'(div_reg);
          default:   rdata_reg <= '0;
        endcase
      end else begin
        rdata_reg <= '0;
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Directed and randomized bench for spi_master; expected bytes, bit streams and
// timing come from the SPI mode-0 rules, not from the RTL structure.
module tb_spi_master;
  import spi_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0;
  logic [3:0]  we = 4'd0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        sclk;
  logic        mosi;
  logic        miso = 1'b0;
  logic        cs_n;

  int total = 0;
  int bad = 0;

  spi_master dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_n  (cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; we = 4'hF;
    @(negedge clk);
    sel = 1'b0; we = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; re = 1'b1;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    d = rdata;
  endtask

  // Reference: received byte depends only on what the slave drives.
  function automatic logic [7:0] exp_rx(input int mode, input logic [7:0] tx, input logic [7:0] pat);
    if (mode == 0) return tx;
    if (mode == 1) return 8'hFF;
    return pat;
  endfunction

  // mode 0: miso looped to mosi, 1: miso tied high, 2: miso plays pat MSB first
  task automatic run_xfer(input logic [7:0] tx, input int div, input int mode,
                          input logic [7:0] pat, input int wr_at, input logic [7:0] wr_val,
                          input int rd_at, output logic [7:0] rd_val,
                          output logic [7:0] bits, output int busy_cyc,
                          output int rises, output bit toggle_ok);
    int limit;
    logic prev;
    limit = 16 * (div + 1) + 40;
    bits = '0; busy_cyc = 0; rises = 0; toggle_ok = 1'b1; prev = 1'b0;
    bus_write(ADDR_DATA, {24'h0, tx});
    while (dut.busy && busy_cyc < limit) begin
      busy_cyc++;
      if (sclk && !prev) begin
        bits = {bits[6:0], mosi};
        rises++;
      end
      if (div == 0 && busy_cyc > 1 && sclk == prev) toggle_ok = 1'b0;
      prev = sclk;
      if (mode == 0)      miso = mosi;
      else if (mode == 1) miso = 1'b1;
      else if (rises < 8) miso = pat[7 - rises];
      sel = 1'b0; we = 4'h0; re = 1'b0;
      if (busy_cyc == wr_at) begin
        sel = 1'b1; addr = ADDR_DATA; wdata = {24'h0, wr_val}; we = 4'hF;
      end
      if (busy_cyc == rd_at) begin
        sel = 1'b1; addr = ADDR_DATA; re = 1'b1;
      end
      @(negedge clk);
    end
    sel = 1'b0; we = 4'h0; re = 1'b0;
    rd_val = rdata[7:0];
    $display("xfer tx=%02h div=%0d mode=%0d mosi=%02h busy=%0d", tx, div, mode, bits, busy_cyc);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  rv;
    logic [7:0]  bits;
    logic [7:0]  tx;
    logic [7:0]  pat;
    int          bc;
    int          nr;
    int          dv;
    bit          tog;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    bus_read(ADDR_CTRL, d); chk("rst_ctrl", d, 32'd0);
    @(negedge clk);         chk("rdata_idle_zero", rdata, 32'd0);
    bus_read(ADDR_DIV, d);  chk("rst_div", d, 32'd3);

    // Offset 3 ignores writes and reads zero
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d);      chk("off3_read", d, 32'd0);
    bus_read(ADDR_DIV, d);  chk("off3_div_kept", d, 32'd3);
    bus_read(ADDR_CTRL, d); chk("off3_ctrl_kept", d, 32'd0);

    // Chip select is software controlled
    bus_write(ADDR_CTRL, 32'd1);
    chk("cs_n_low", 32'(cs_n), 32'd0);
    bus_read(ADDR_CTRL, d); chk("ctrl_cs", d, 32'd1);
    bus_write(ADDR_CTRL, 32'd0);
    chk("cs_n_high", 32'(cs_n), 32'd1);

    // DIV=0, 0xA5 looped back
    bus_write(ADDR_DIV, 32'd0);
    bus_read(ADDR_DIV, d);  chk("div0_read", d, 32'd0);
    run_xfer(8'hA5, 0, 0, 8'h00, -1, 8'h00, -1, rv, bits, bc, nr, tog);
    chk("a5_busy", 32'(bc), 32'd16);
    chk("a5_mosi", 32'(bits), 32'hA5);
    chk("a5_rises", 32'(nr), 32'd8);
    chk("a5_toggle", 32'(tog), 32'd1);
    chk("a5_idle_sclk", 32'(sclk), 32'd0);
    bus_read(ADDR_CTRL, d); chk("a5_ctrl_valid", d, 32'd4);
    bus_read(ADDR_DATA, d); chk("a5_data", d, 32'hA5);
    bus_read(ADDR_CTRL, d); chk("a5_ctrl_clr", d, 32'd0);

    // DIV=3, miso high, 0x00 sent
    bus_write(ADDR_DIV, 32'd3);
    run_xfer(8'h00, 3, 1, 8'h00, -1, 8'h00, -1, rv, bits, bc, nr, tog);
    chk("ff_busy", 32'(bc), 32'd64);
    chk("ff_mosi", 32'(bits), 32'h00);
    bus_read(ADDR_DATA, d); chk("ff_data", d, 32'hFF);

    // DATA write while busy is ignored
    bus_write(ADDR_DIV, 32'd1);
    run_xfer(8'h12, 1, 0, 8'h00, 5, 8'h34, -1, rv, bits, bc, nr, tog);
    chk("ign_busy", 32'(bc), 32'd32);
    chk("ign_mosi", 32'(bits), 32'h12);
    bus_read(ADDR_DATA, d); chk("ign_data", d, 32'h12);

    // Read coinciding with completion: old byte returned, rx_valid kept
    run_xfer(8'h3C, 1, 0, 8'h00, -1, 8'h00, -1, rv, bits, bc, nr, tog);
    bus_write(ADDR_DIV, 32'd0);
    run_xfer(8'hC3, 0, 0, 8'h00, -1, 8'h00, 16, rv, bits, bc, nr, tog);
    chk("coll_busy", 32'(bc), 32'd16);
    chk("coll_old", 32'(rv), 32'h3C);
    bus_read(ADDR_CTRL, d); chk("coll_valid", d, 32'd4);
    bus_read(ADDR_DATA, d); chk("coll_new", d, 32'hC3);
    bus_read(ADDR_CTRL, d); chk("coll_clr", d, 32'd0);

    // Randomized transfers against the model
    for (int i = 0; i < 4; i++) begin
      tx  = 8'($urandom);
      pat = 8'($urandom);
      dv  = int'($urandom_range(0, 3));
      bus_write(ADDR_DIV, 32'(dv));
      run_xfer(tx, dv, 2, pat, -1, 8'h00, -1, rv, bits, bc, nr, tog);
      chk("rnd_busy", 32'(bc), 32'(16 * (dv + 1)));
      chk("rnd_mosi", 32'(bits), 32'(tx));
      bus_read(ADDR_DATA, d); chk("rnd_data", d, 32'(exp_rx(2, tx, pat)));
    end

    // Reset in the middle of a transfer
    bus_write(ADDR_CTRL, 32'd1);
    bus_write(ADDR_DIV, 32'd1);
    bus_write(ADDR_DATA, 32'hF0);
    repeat (6) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_sclk", 32'(sclk), 32'd0);
    chk("mid_rst_cs_n", 32'(cs_n), 32'd1);
    chk("mid_rst_busy", 32'(dut.busy), 32'd0);
    chk("mid_rst_mosi", 32'(mosi), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(ADDR_CTRL, d); chk("mid_rst_ctrl", d, 32'd0);
    bus_read(ADDR_DIV, d);  chk("mid_rst_div", d, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
